// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access size codes and controller states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, store-data replication, load
// lane selection with sign/zero extension, and alignment checking.
module dmem_lane_align #(
  parameter int DATA_WIDTH = 32,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int OFS = $clog2(DATA_WIDTH / 8)
) (
  input  logic [1:0]            size_i,
  input  logic [OFS-1:0]        offset_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rawWord_i,
  output logic [BYTES-1:0]      byteEn_o,
  output logic [DATA_WIDTH-1:0] storeData_o,
  output logic [DATA_WIDTH-1:0] loadData_o,
  output logic                  alignErr_o
);
  import dmem_pkg::*;

  size_e                 size;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  extBit;

  assign size    = size_e'(size_i);
  assign shifted = rawWord_i >> {offset_i, 3'b000};

  always_comb begin
    byteEn_o    = '0;
    storeData_o = wdata_i;
    loadData_o  = '0;
    alignErr_o  = 1'b0;
    extBit      = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteEn_o    = BYTES'(1) << offset_i;
        storeData_o = {BYTES{wdata_i[7:0]}};
        extBit      = shifted[7] & ~unsigned_i;
        loadData_o  = {{(DATA_WIDTH-8){extBit}}, shifted[7:0]};
      end
      SZ_HALF: begin
        alignErr_o  = offset_i[0];
        byteEn_o    = BYTES'(3) << offset_i;
        storeData_o = {(BYTES/2){wdata_i[15:0]}};
        extBit      = shifted[15] & ~unsigned_i;
        loadData_o  = {{(DATA_WIDTH-16){extBit}}, shifted[15:0]};
      end
      SZ_WORD: begin
        alignErr_o = (offset_i != '0);
        byteEn_o   = '1;
        loadData_o = rawWord_i;
      end
      default: alignErr_o = 1'b1;
    endcase
    // A misaligned store must not touch any lane.
    if (alignErr_o) byteEn_o = '0;
  end

endmodule

// File: rtl/dmem_byte_lane.sv
// Byte-addressed, word-organised data memory with a post-reset clear sweep.
// Define DMEM_DEBUG_PORT_EN to add a registered read-only debug port.
module dmem_byte_lane
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int IDXW = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err_align,
`ifdef DMEM_DEBUG_PORT_EN
  input  logic                  i_dbg_re,
  input  logic [IDXW-1:0]       i_dbg_addr,
  output logic [DATA_WIDTH-1:0] o_dbg_data,
  output logic                  o_dbg_valid,
`endif
  output logic                  o_err_range
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e                state_q, state_d;
  logic [IDXW-1:0]       clrCnt_q, clrCnt_d;
  logic                  done_q, done_d;
  logic                  errAlign_q, errAlign_d;
  logic                  errRange_q, errRange_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [IDXW-1:0]       wordIdx;
  logic                  rangeErr, alignErr, accept, wrEn;
  logic [BYTES-1:0]      byteEn;
  logic [DATA_WIDTH-1:0] storeData, loadData, rawWord;

  assign wordAddr = i_addr >> OFS;
  assign wordIdx  = wordAddr[IDXW-1:0];
  assign rangeErr = (wordAddr >> IDXW) != '0;
  assign rawWord  = mem[wordIdx];
  assign o_ready  = (state_q == IDLE);
  assign accept   = i_req & o_ready;
  assign wrEn     = accept & i_we & ~rangeErr;

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size_i      (i_size),
    .offset_i    (i_addr[OFS-1:0]),
    .unsigned_i  (i_unsigned),
    .wdata_i     (i_wdata),
    .rawWord_i   (rawWord),
    .byteEn_o    (byteEn),
    .storeData_o (storeData),
    .loadData_o  (loadData),
    .alignErr_o  (alignErr)
  );

  always_comb begin
    state_d    = state_q;
    clrCnt_d   = clrCnt_q;
    done_d     = accept;
    errAlign_d = accept & alignErr;
    errRange_d = accept & rangeErr;
    rdata_d    = '0;
    case (state_q)
      INIT: begin
        clrCnt_d = clrCnt_q + IDXW'(1);
        if (clrCnt_q == IDXW'(MEM_DEPTH - 1)) begin
          state_d  = IDLE;
          clrCnt_d = '0;
        end
      end
      IDLE: ;
      default: state_d = INIT;
    endcase
    if (accept && !i_we && !alignErr && !rangeErr) rdata_d = loadData;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= INIT;
      clrCnt_q   <= '0;
      done_q     <= 1'b0;
      errAlign_q <= 1'b0;
      errRange_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clrCnt_q   <= clrCnt_d;
      done_q     <= done_d;
      errAlign_q <= errAlign_d;
      errRange_q <= errRange_d;
      rdata_q    <= rdata_d;
    end
  end

  // The array has no reset; the sweep is what guarantees zeroed contents.
  always_ff @(posedge i_clk) begin
    if (state_q == INIT) begin
      mem[clrCnt_q] <= '0;
    end else if (wrEn) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
      end
    end
  end

  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_err_align = errAlign_q;
  assign o_err_range = errRange_q;

`ifdef DMEM_DEBUG_PORT_EN
  logic [DATA_WIDTH-1:0] dbgData_q;
  logic                  dbgValid_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dbgData_q  <= '0;
      dbgValid_q <= 1'b0;
    end else begin
      dbgValid_q <= i_dbg_re;
      if (i_dbg_re) dbgData_q <= (state_q == INIT) ? '0 : mem[i_dbg_addr];
    end
  end

  assign o_dbg_data  = dbgData_q;
  assign o_dbg_valid = dbgValid_q;
`endif

endmodule

// File: tb/tb_dmem_byte_lane.sv
// Scoreboard bench for dmem_byte_lane: a byte-array reference model predicts
// each response, and a negedge monitor pops and compares on every o_done.
module tb_dmem_byte_lane;
  localparam int MEM_DEPTH = 1024;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          i_rst, i_req, i_we, i_unsigned;
  logic [1:0]    i_size;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic          o_ready, o_done, o_err_align, o_err_range;
  logic [DW-1:0] o_rdata;
`ifdef DMEM_DEBUG_PORT_EN
  logic          i_dbg_re;
  logic [9:0]    i_dbg_addr;
  logic [DW-1:0] o_dbg_data;
  logic          o_dbg_valid;
`endif

  always #5 clk = ~clk;

  dmem_byte_lane #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_err_align (o_err_align),
`ifdef DMEM_DEBUG_PORT_EN
    .i_dbg_re    (i_dbg_re),
    .i_dbg_addr  (i_dbg_addr),
    .o_dbg_data  (o_dbg_data),
    .o_dbg_valid (o_dbg_valid),
`endif
    .o_err_range (o_err_range)
  );

  typedef struct {
    logic        isLoad;
    logic [31:0] rdata;
    logic        ea;
    logic        er;
    int          cyc;
  } exp_t;

  exp_t  expQ[$];
  string labelQ[$];
  int    checks = 0;
  int    failures = 0;
  int    cycleCnt = 0;
  logic [7:0] modelMem [MEM_DEPTH*4];

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Little-endian byte model: lane k of a word holds byte address word*4+k.
  function automatic void modelAccess(input logic we, input logic [1:0] size, input logic uns,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic ea, output logic er);
    int n;
    logic [31:0] v;
    ea = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    er = (addr >> 2) >= 32'(MEM_DEPTH);
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    rdata = 32'h0;
    if (ea || er) return;
    if (we) begin
      for (int k = 0; k < n; k++) modelMem[int'(addr) + k] = wdata[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = modelMem[int'(addr) + k];
      if (!uns && n < 4 && v[8*n-1]) begin
        for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      end
      rdata = v;
    end
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < MEM_DEPTH*4; i++) modelMem[i] = 8'h00;
  endfunction

  // Called just after a posedge; the request is taken at the next edge.
  task automatic applyStimulus(input string lbl, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic useExp, input logic [31:0] expData,
                               input logic expEa, input logic expEr);
    exp_t e;
    logic [31:0] md;
    logic ea, er;
    modelAccess(we, size, uns, addr, wdata, md, ea, er);
    i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
    e.isLoad = !we;
    e.rdata  = useExp ? expData : md;
    e.ea     = useExp ? expEa : ea;
    e.er     = useExp ? expEr : er;
    e.cyc    = cycleCnt + 1;
    if (o_ready === 1'b1) begin
      expQ.push_back(e);
      labelQ.push_back(lbl);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic countSweep(output int n);
    n = 0;
    while (o_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic holdIgnoredStore();
    i_req = 1'b1; i_we = 1'b1; i_size = 2'd2; i_unsigned = 1'b0;
    i_addr = 32'h0; i_wdata = 32'hCAFEF00D;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string lbl;
    if (o_done === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_done: got o_done=1 at cycle %0d expected no response", cycleCnt);
      end else begin
        e   = expQ.pop_front();
        lbl = labelQ.pop_front();
        if (e.cyc != cycleCnt || o_err_align !== e.ea || o_err_range !== e.er ||
            (e.isLoad && o_rdata !== e.rdata)) begin
          failures++;
          $display("[TB] FAIL %s: got cyc=%0d rdata=0x%08h align=%b range=%b expected cyc=%0d rdata=0x%08h align=%b range=%b",
                   lbl, cycleCnt, o_rdata, o_err_align, o_err_range, e.cyc, e.rdata, e.ea, e.er);
        end
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [1:0]  sz;
    i_rst = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'd0; i_unsigned = 1'b0;
    i_addr = '0; i_wdata = '0;
`ifdef DMEM_DEBUG_PORT_EN
    i_dbg_re = 1'b0; i_dbg_addr = '0;
`endif
    clearModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(o_ready), 32'h0);
    checkOutput("reset_done", 32'(o_done), 32'h0);
    checkOutput("reset_rdata", o_rdata, 32'h0);
    checkOutput("reset_err_align", 32'(o_err_align), 32'h0);
    checkOutput("reset_err_range", 32'(o_err_range), 32'h0);
`ifdef DMEM_DEBUG_PORT_EN
    checkOutput("reset_dbg_data", o_dbg_data, 32'h0);
    checkOutput("reset_dbg_valid", 32'(o_dbg_valid), 32'h0);
`endif

    holdIgnoredStore();
    i_rst = 1'b1;
    countSweep(n);
    i_req = 1'b0;
    checkOutput("sweep_len", n, 32'd1024);

    applyStimulus("ignored_store_word0", 0, 2'd2, 0, 32'h0, 0, 1, 32'h0, 0, 0);
    applyStimulus("last_word_zero", 0, 2'd2, 0, 32'h0FFC, 0, 1, 32'h0, 0, 0);
    applyStimulus("st_word_10", 1, 2'd2, 0, 32'h10, 32'h11223344, 1, 32'h0, 0, 0);
    applyStimulus("st_byte_12", 1, 2'd0, 0, 32'h12, 32'h5A5A5AAB, 1, 32'h0, 0, 0);
    applyStimulus("ld_word_10", 0, 2'd2, 0, 32'h10, 0, 1, 32'h11AB3344, 0, 0);
    applyStimulus("ld_byte_12_s", 0, 2'd0, 0, 32'h12, 0, 1, 32'hFFFFFFAB, 0, 0);
    applyStimulus("ld_byte_12_u", 0, 2'd0, 1, 32'h12, 0, 1, 32'h000000AB, 0, 0);
    applyStimulus("st_word_20", 1, 2'd2, 0, 32'h20, 32'h80007FFF, 1, 32'h0, 0, 0);
    applyStimulus("ld_half_20_s", 0, 2'd1, 0, 32'h20, 0, 1, 32'h00007FFF, 0, 0);
    applyStimulus("ld_half_22_s", 0, 2'd1, 0, 32'h22, 0, 1, 32'hFFFF8000, 0, 0);
    applyStimulus("ld_half_22_u", 0, 2'd1, 1, 32'h22, 0, 1, 32'h00008000, 0, 0);
    applyStimulus("st_half_21_misalign", 1, 2'd1, 0, 32'h21, 32'h00001234, 1, 32'h0, 1, 0);
    applyStimulus("ld_word_20_unchanged", 0, 2'd2, 0, 32'h20, 0, 1, 32'h80007FFF, 0, 0);
    applyStimulus("ld_word_1000_range", 0, 2'd2, 0, 32'h1000, 0, 1, 32'h0, 0, 1);
    applyStimulus("ld_size3", 0, 2'd3, 0, 32'h30, 0, 1, 32'h0, 1, 0);
    applyStimulus("b2b_st_40", 1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 1, 32'h0, 0, 0);
    applyStimulus("b2b_ld_40", 0, 2'd2, 0, 32'h40, 0, 1, 32'hDEADBEEF, 0, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      n  = $urandom_range(0, 15);
      a  = (n == 0) ? $urandom : (n == 1) ? 32'h0FF0 + $urandom_range(0, 15) : $urandom_range(0, 127);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      applyStimulus("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                    0, 32'h0, 0, 0);
    end
    repeat (3) @(posedge clk);
    #1;

    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    holdIgnoredStore();
    clearModel();
    i_rst = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    checkOutput("midsweep_ready_low", 32'(o_ready), 32'h0);
    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midsweep_reset_ready", 32'(o_ready), 32'h0);
    i_rst = 1'b1;
    countSweep(n);
    i_req = 1'b0;
    checkOutput("resweep_len", n, 32'd1024);

    applyStimulus("post_ld_0", 0, 2'd2, 0, 32'h0, 0, 1, 32'h0, 0, 0);
    applyStimulus("post_ld_10", 0, 2'd2, 0, 32'h10, 0, 1, 32'h0, 0, 0);
    applyStimulus("post_ld_40", 0, 2'd2, 0, 32'h40, 0, 1, 32'h0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("post_random_ld", 0, 2'd2, 0, {20'h0, 2'($urandom_range(0, 3)), 8'($urandom), 2'b00},
                    0, 0, 32'h0, 0, 0);
    end

`ifdef DMEM_DEBUG_PORT_EN
    i_dbg_re = 1'b1; i_dbg_addr = 10'd4;
    @(posedge clk); #1;
    i_dbg_re = 1'b0;
    checkOutput("dbg_idx4_valid", 32'(o_dbg_valid), 32'h1);
    checkOutput("dbg_idx4_zero", o_dbg_data, 32'h0);
    applyStimulus("dbg_st_10", 1, 2'd2, 0, 32'h10, 32'h12345678, 1, 32'h0, 0, 0);
    i_dbg_re = 1'b1; i_dbg_addr = 10'd4;
    @(posedge clk); #1;
    i_dbg_re = 1'b0;
    checkOutput("dbg_idx4_written", o_dbg_data, 32'h12345678);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_byte_lane.md
# dmem_byte_lane

Parametrised successor to the pipeline data memory: a byte-addressed, word-organised synchronous RAM with per-byte write enables, correct per-lane sign/zero extension, alignment and range checking, and a single-cycle request/response handshake. It sits in the MEM stage of the pipeline, between the ALU address path and the write-back mux. After reset it clears its contents with a hardware sweep before accepting traffic.

## Interface
- `MEM_DEPTH`, 1024: number of words; power of two.
- `DATA_WIDTH`, 32: word width in bits; 32 or 64.
- `ADDR_WIDTH`, 32: byte-address width.
- `i_clk`  in  1  single clock.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_req`  in  1  access request; accepted when `i_req & o_ready`.
- `i_we`  in  1  1 = store, 0 = load.
- `i_size`  in  2  00 byte, 01 half, 10 full word, 11 illegal.
- `i_unsigned`  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `i_addr`  in  ADDR_WIDTH  byte address.
- `i_wdata`  in  DATA_WIDTH  store data, right-justified.
- `o_ready`  out  1  low during the clear sweep.
- `o_done`  out  1  one-cycle pulse, one per accepted request.
- `o_rdata`  out  DATA_WIDTH  load result; valid while `o_done` is high for a load.
- `o_err_align`  out  1  misaligned or illegal size; qualified by `o_done`.
- `o_err_range`  out  1  word index ≥ `MEM_DEPTH`; qualified by `o_done`.

## Operation
- BYTES = DATA_WIDTH/8 and OFS = log2(BYTES).
- Word index = `i_addr >> OFS`. Lane offset = `i_addr[OFS-1:0]`.
- Alignment rules:
  - Byte: any offset.
  - Half: offset[0] = 0.
  - Full word: offset = 0.
  - Size 11: always flagged in `o_err_align`.
- Stores:
  - Byte enables are derived from size and offset; only the enabled lanes are written.
  - Byte/half data is taken from `i_wdata[7:0]`/`[15:0]` and replicated to the target lane.
  - A store with either error flag set writes nothing.
- Loads:
  - The addressed lane is selected and shifted to bit 0.
  - Sign-extension uses the MSB of the selected byte or half, not the word MSB.
  - For a full-word load the extension bit is ignored.
  - An errored load returns `o_rdata` = 0.
- FSM states:
  - INIT: clear counter runs 0..MEM_DEPTH-1, writing 0 to one word per cycle; `o_ready` = 0. Go to IDLE after writing the last word.
  - IDLE: `o_ready` = 1; requests are accepted every cycle.
- Reset: asserting `i_rst` in any state, including mid-sweep, returns to INIT with the counter at 0 and the sweep restarts.
- Reset values: `o_ready` 0, `o_done` 0, `o_rdata` 0, `o_err_align` 0, `o_err_range` 0. The counter resets to 0.

## Timing
- All state changes on `posedge i_clk`. Memory is written on the accepting edge.
- Latency is 1 cycle: a request accepted at edge N gives `o_done`, `o_rdata` and the error flags after edge N, valid for one cycle.
- Back-to-back requests are allowed with throughput 1/cycle. A load accepted at N+1, to a word stored at N, returns the new data.
- Requests presented while `o_ready` = 0 are ignored: no `o_done` and no write.
- `o_ready` rises MEM_DEPTH cycles after `i_rst` deasserts.

## Configuration
- Macro `DMEM_DEBUG_PORT_EN`.
- When defined, the block adds a read-only debug port for the UART debug unit:
  - `i_dbg_re` in 1.
  - `i_dbg_addr` in log2(MEM_DEPTH), a word index.
  - `o_dbg_data` out DATA_WIDTH.
  - `o_dbg_valid` out 1.
- Debug port behaviour:
  - Registered full-word read with 1-cycle latency, independent of the main port. It has no effect on the main port's timing.
  - `o_dbg_data` returns the word value as it was before any write on the same edge.
  - During INIT, debug reads return 0.
  - Reset value of `o_dbg_data` and `o_dbg_valid` is 0.
- When not defined, these ports and their logic are absent.

## Structure
- Package `dmem_pkg` holds:
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - The FSM state enum (INIT, IDLE).
- Sub-module `dmem_lane_align` is purely combinational. It takes size, offset, unsigned flag, wdata and the raw word, and produces:
  - Byte enables.
  - Lane-replicated store data.
  - The extended load value.
  - The alignment error.
- The top level owns the RAM array, FSM, clear counter, response registers and optional debug port.

## Test plan
- Sweep: release `i_rst` → `o_ready` stays 0 for exactly 1024 cycles. A full-word load at 0x0FFC then returns 0x00000000.
- Byte lanes:
  - Store word 0x11223344 at 0x10, then store byte 0xAB at 0x12.
  - Word load from 0x10 → 0x11AB3344.
  - Load byte at 0x12, signed → 0xFFFFFFAB; unsigned → 0x000000AB.
- Half extension:
  - Store word 0x80007FFF at 0x20.
  - Load half at 0x20, signed → 0x00007FFF.
  - Load half at 0x22, signed → 0xFFFF8000; unsigned → 0x00008000.
- Errors:
  - Half store to 0x21 → `o_err_align` = 1, memory unchanged.
  - Word load at 0x1000 with MEM_DEPTH = 1024 → `o_err_range` = 1, `o_rdata` = 0.
  - Size 11 → `o_err_align` = 1.
- Back-to-back: store 0xDEADBEEF at 0x40 at edge N, load 0x40 at N+1 → `o_rdata` = 0xDEADBEEF with `o_done` after N+1. `o_done` is high on both consecutive cycles.
- Reset mid-sweep: assert `i_rst` at counter 500, release → `o_ready` low for a full 1024 cycles. With `DMEM_DEBUG_PORT_EN`, a debug read of index 4 after the sweep → 0.
